// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and latency helper
// for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_SHRA = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_ROR  = 4'hA;
  localparam logic [3:0] OP_ROL  = 4'hB;
  localparam logic [3:0] OP_NEG  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  function automatic int iter_lat(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Launch/complete bundle between the control unit
// and the multicycle ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_out2;
  logic             zero;
  logic             div_by_zero;
  logic             illegal_op;

  modport master (
    output start, op, A, B,
    input  busy, done, alu_out, alu_out2,
    input  zero, div_by_zero, illegal_op
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, alu_out, alu_out2,
    output zero, div_by_zero, illegal_op
  );

endinterface

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: radix-2 Booth multiply
// and restoring divide on magnitudes.
module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             dz,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q1_q, q1_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   m_ext, sum, shl;
  logic [WIDTH+1:0] diff;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? -v : v;
  endfunction

  always_comb begin
    acc_d = acc_q;
    sr_d  = sr_q;
    m_d   = m_q;
    q1_d  = q1_q;
    div_d = div_q;
    dz_d  = dz_q;
    nq_d  = nq_q;
    nr_d  = nr_q;
    cnt_d = cnt_q;
    m_ext = {m_q[WIDTH-1], m_q};
    shl   = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
    diff  = {1'b0, shl} - {2'b00, m_q};
    case ({sr_q[0], q1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    if (load) begin
      div_d = div_mode;
      cnt_d = '0;
      acc_d = '0;
      q1_d  = 1'b0;
      nq_d  = a[WIDTH-1] ^ b[WIDTH-1];
      nr_d  = a[WIDTH-1];
      if (div_mode) begin
        dz_d = (b == '0);
        sr_d = (b == '0) ? a : mag(a);
        m_d  = mag(b);
      end else begin
        dz_d = 1'b0;
        sr_d = b;
        m_d  = a;
      end
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        if (!diff[WIDTH+1]) begin
          acc_d = diff[WIDTH:0];
          sr_d  = {sr_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shl;
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        sr_d  = {sum[0], sr_q[WIDTH-1:1]};
        q1_d  = sr_q[0];
      end
    end else if (finish) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    lo = sr_q;
    hi = acc_q[WIDTH-1:0];
    if (div_q) begin
      if (dz_q) begin
        lo = '1;
        hi = sr_q;
      end else begin
        lo = nq_q ? -sr_q : sr_q;
        hi = nr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign dz   = dz_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc_q <= '0;
      sr_q  <= '0;
      m_q   <= '0;
      q1_q  <= 1'b0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      nq_q  <= 1'b0;
      nr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sr_q  <= sr_d;
      m_q   <= m_d;
      q1_q  <= q1_d;
      div_q <= div_d;
      dz_q  <= dz_d;
      nq_q  <= nq_d;
      nr_q  <= nr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle ops complete in one edge,
// MUL/DIV run through the shared iterative unit.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic clock,
  input  logic clear,
  alu_multicycle_if.slave bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0]   res;
  logic               res_ill;
  logic [SHAMT_W-1:0] sh;
  logic               load, step, finish;
  logic               is_div, is_iter;
  logic               last, u_dz;
  logic [WIDTH-1:0]   u_lo, u_hi;

  assign sh      = bus.B[SHAMT_W-1:0];
  assign is_div  = (bus.op == OP_DIV);
  assign is_iter = is_div || (bus.op == OP_MUL);

  always_comb begin
    res     = '0;
    res_ill = 1'b0;
    case (bus.op)
      OP_ADD:  res = bus.A + bus.B;
      OP_SUB:  res = bus.A - bus.B;
      OP_AND:  res = bus.A & bus.B;
      OP_OR:   res = bus.A | bus.B;
      OP_SHR:  res = bus.A >> sh;
      OP_SHRA: res = $signed(bus.A) >>> sh;
      OP_SHL:  res = bus.A << sh;
      // a shift by WIDTH yields 0, so amount 0 passes A through
      OP_ROR:  res = (bus.A >> sh)
                   | (bus.A << (WIDTH - int'(sh)));
      OP_ROL:  res = (bus.A << sh)
                   | (bus.A >> (WIDTH - int'(sh)));
      OP_NEG:  res = -bus.A;
      OP_NOT:  res = ~bus.A;
      OP_DIV,
      OP_MUL:  res = '0;
      default: res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    out2_d  = out2_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    ill_d   = ill_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_iter) begin
            load    = 1'b1;
            state_d = (is_div && bus.B == '0) ? S_FIX : S_RUN;
          end else begin
            out_d  = res;
            out2_d = '0;
            zero_d = (res == '0);
            dz_d   = 1'b0;
            ill_d  = res_ill;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        finish  = 1'b1;
        out_d   = u_lo;
        out2_d  = u_hi;
        zero_d  = (u_lo == '0);
        dz_d    = u_dz;
        ill_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      out2_q  <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      out2_q  <= out2_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .step     (step),
    .finish   (finish),
    .div_mode (is_div),
    .a        (bus.A),
    .b        (bus.B),
    .last     (last),
    .dz       (u_dz),
    .lo       (u_lo),
    .hi       (u_hi)
  );

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.alu_out     = out_q;
  assign bus.alu_out2    = out2_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dz_q;
  assign bus.illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations are
// queued at launch and checked on each done pulse.
module tb_alu_multicycle;
  import alu_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        dz;
    logic        ill;
    int          lat;
    int          bsy;
    int          t0;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_multicycle_if #(.WIDTH(32)) bus();

  alu_multicycle #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag,
                              input logic [31:0] lo,
                              input logic [31:0] hi,
                              input logic dz,
                              input logic ill,
                              input int lat,
                              input int bsy);
    exp_t e;
    e.tag = tag;
    e.lo  = lo;
    e.hi  = hi;
    e.z   = (lo == 32'h0);
    e.dz  = dz;
    e.ill = ill;
    e.lat = lat;
    e.bsy = bsy;
    e.t0  = 0;
    return e;
  endfunction

  function automatic exp_t model(input string tag,
                                 input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    longint      sa, sb2, p;
    logic [31:0] r;
    int          sh;
    exp_t        e;
    e = mk(tag, 32'h0, 32'h0, 1'b0, 1'b0, 1, 0);
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    sh  = int'(b[4:0]);
    r   = a;
    case (op)
      4'h1: e.lo = a + b;
      4'h2: e.lo = a - b;
      4'h3: begin
        if (b == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
          e.lat = 2; e.bsy = 1;
        end else begin
          p = sa / sb2; e.lo = p[31:0];
          p = sa % sb2; e.hi = p[31:0];
          e.lat = 34; e.bsy = 33;
        end
      end
      4'h4: begin
        p = sa * sb2;
        e.lo = p[31:0]; e.hi = p[63:32];
        e.lat = 34; e.bsy = 33;
      end
      4'h5: e.lo = a & b;
      4'h6: e.lo = a | b;
      4'h7: begin repeat (sh) r = {1'b0, r[31:1]}; e.lo = r; end
      4'h8: begin repeat (sh) r = {r[31], r[31:1]}; e.lo = r; end
      4'h9: begin repeat (sh) r = {r[30:0], 1'b0}; e.lo = r; end
      4'hA: begin repeat (sh) r = {r[0], r[31:1]}; e.lo = r; end
      4'hB: begin repeat (sh) r = {r[30:0], r[31]}; e.lo = r; end
      4'hC: e.lo = 32'h0 - a;
      4'hD: e.lo = ~a;
      default: e.ill = 1'b1;
    endcase
    e.z = (e.lo == 32'h0);
    return e;
  endfunction

  always @(negedge clock) begin
    if (bus.busy) busy_cnt++;
    if (!clear && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_lo"}, bus.alu_out, mon_e.lo);
        check({mon_e.tag, "_hi"}, bus.alu_out2, mon_e.hi);
        check({mon_e.tag, "_zero"}, bus.zero, mon_e.z);
        check({mon_e.tag, "_dz"}, bus.div_by_zero, mon_e.dz);
        check({mon_e.tag, "_ill"}, bus.illegal_op, mon_e.ill);
        check({mon_e.tag, "_lat"}, cyc - mon_e.t0, mon_e.lat);
        check({mon_e.tag, "_busy"}, busy_cnt, mon_e.bsy);
      end
    end
  end

  task automatic launch(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input exp_t e);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    e.t0      = cyc;
    busy_cnt  = 0;
    sb.push_back(e);
  endtask

  task automatic drain();
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && sb.size() != 0; i++)
      @(negedge clock);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 64'd0);
      sb.delete();
    end
  endtask

  logic [3:0]  ops [13];
  logic [3:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 13; i++) ops[i] = 4'(i + 1);
    bus.start = 1'b0;
    bus.op    = 4'h0;
    bus.A     = 32'h0;
    bus.B     = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_out", bus.alu_out, 64'h0);
    check("rst_out2", bus.alu_out2, 64'h0);
    check("rst_zero", bus.zero, 64'h0);
    check("rst_dz", bus.div_by_zero, 64'h0);
    check("rst_ill", bus.illegal_op, 64'h0);
    check("rst_done", bus.done, 64'h0);
    check("rst_busy", bus.busy, 64'h0);
    clear = 1'b0;

    launch(OP_ADD, 32'h7FFF_FFFF, 32'h1,
           mk("add", 32'h8000_0000, 32'h0, 0, 0, 1, 0));
    launch(OP_SUB, 32'h5, 32'h9,
           mk("sub", 32'hFFFF_FFFC, 32'h0, 0, 0, 1, 0));
    drain();
    launch(OP_MUL, 32'hFFFF_FFF9, 32'h6,
           mk("mul", 32'hFFFF_FFD6, 32'hFFFF_FFFF, 0, 0, 34, 33));
    drain();
    launch(OP_DIV, 32'hFFFF_FFEF, 32'h5,
           mk("div", 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, 0, 34, 33));
    drain();
    launch(OP_DIV, 32'h1234, 32'h0,
           mk("div0", 32'hFFFF_FFFF, 32'h1234, 1, 0, 2, 1));
    drain();
    launch(OP_ADD, 32'h0, 32'h0,
           mk("add0", 32'h0, 32'h0, 0, 0, 1, 0));
    drain();
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           mk("divmin", 32'h8000_0000, 32'h0, 0, 0, 34, 33));
    drain();
    launch(OP_ROR, 32'h8000_0001, 32'h4,
           mk("ror", 32'h1800_0000, 32'h0, 0, 0, 1, 0));
    launch(OP_SHRA, 32'h8000_0000, 32'd31,
           mk("shra", 32'hFFFF_FFFF, 32'h0, 0, 0, 1, 0));
    launch(4'hF, 32'h1234, 32'h5678,
           mk("illegal", 32'h0, 32'h0, 0, 1, 1, 0));
    launch(OP_ROL, 32'hDEAD_BEEF, 32'd32,
           mk("rol0", 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 0));
    drain();

    for (int i = 0; i < 16; i++) begin
      rop = ops[$urandom_range(0, 12)];
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      launch(rop, ra, rb, model($sformatf("rnd%0d", i), rop, ra, rb));
      drain();
    end

    launch(OP_MUL, 32'hFFFF_FFF9, 32'h6,
           mk("mul_ign", 32'hFFFF_FFD6, 32'hFFFF_FFFF, 0, 0, 34, 33));
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.A     = 32'h1;
    bus.B     = 32'h2;
    drain();

    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = OP_MUL;
    bus.A     = 32'h1234_5678;
    bus.B     = 32'h9ABC_DEF0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    clear = 1'b1;
    #1;
    check("abort_out", bus.alu_out, 64'h0);
    check("abort_out2", bus.alu_out2, 64'h0);
    check("abort_zero", bus.zero, 64'h0);
    check("abort_busy", bus.busy, 64'h0);
    check("abort_done", bus.done, 64'h0);
    check("abort_state", dut.state_q, S_IDLE);
    @(negedge clock);
    clear = 1'b0;
    repeat (40) @(negedge clock);
    launch(OP_ADD, 32'h3, 32'h4,
           mk("post_abort", 32'h7, 32'h0, 0, 0, 1, 0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
